// File: rtl/sweep_pkg.sv
// Shared types and constants for the vector sweep engine: FSM states, signature
// polynomial and legal parameter ranges.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StEmit,
    StDone
  } sweep_state_e;

  // Feedback taps for the 16-bit signature; narrower signatures use the low bits.
  localparam logic [15:0] SWEEP_POLY = 16'h100B;

  localparam int unsigned InWMin     = 1;
  localparam int unsigned InWMax     = 16;
  localparam int unsigned SettleMin  = 1;
  localparam int unsigned SettleMax  = 255;
  localparam int unsigned SettleCntW = 8;

endpackage

// File: rtl/sweep_misr.sv
// Signature register: shift-and-fold LFSR that absorbs one response word per enable.
module sweep_misr
  import sweep_pkg::*;
#(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned OUT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] sig_o
);

  localparam logic [SIG_W-1:0] Poly = SIG_W'(SWEEP_POLY);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (enable) begin
      sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? Poly : '0) ^ SIG_W'(data);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/vector_sweep_engine.sv
// Walks stimulus vectors from first to last (wrapping), lets each settle, samples the
// DUT response and hands out one record per vector over a valid/ready handshake.
module vector_sweep_engine
  import sweep_pkg::*;
#(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W  = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  first_vec,
  input  logic [IN_W-1:0]  last_vec,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IN_W-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_resp,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    rec_count,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned CntW = IN_W + 1;
  localparam logic [SettleCntW-1:0] SettleLoad = SettleCntW'(SETTLE);

  if (IN_W < InWMin || IN_W > InWMax) begin : g_bad_in_w
    $error("vector_sweep_engine: IN_W out of range");
  end
  if (SETTLE < SettleMin || SETTLE > SettleMax) begin : g_bad_settle
    $error("vector_sweep_engine: SETTLE out of range");
  end
  if (OUT_W < 1 || OUT_W > SIG_W) begin : g_bad_out_w
    $error("vector_sweep_engine: OUT_W out of range");
  end

  sweep_state_e           state_q, state_d;
  logic [IN_W-1:0]        last_q, last_d;
  logic [IN_W-1:0]        dut_in_q, dut_in_d;
  logic [IN_W-1:0]        rec_vec_q, rec_vec_d;
  logic [OUT_W-1:0]       rec_resp_q, rec_resp_d;
  logic                   rec_valid_q, rec_valid_d;
  logic [CntW-1:0]        rec_count_q, rec_count_d;
  logic [SettleCntW-1:0]  settle_q, settle_d;
  logic                   sig_clear;
  logic                   sig_enable;
  logic                   handshake;

  assign handshake = rec_valid_q && rec_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    dut_in_d    = dut_in_q;
    rec_vec_d   = rec_vec_q;
    rec_resp_d  = rec_resp_q;
    rec_valid_d = rec_valid_q;
    rec_count_d = rec_count_q;
    settle_d    = settle_q;
    sig_clear   = 1'b0;
    sig_enable  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // A start that coincides with abort is treated as noise and dropped.
        if (start && !abort) begin
          last_d      = last_vec;
          dut_in_d    = first_vec;
          rec_count_d = '0;
          sig_clear   = 1'b1;
          settle_d    = SettleLoad;
          rec_valid_d = 1'b0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_q <= SettleCntW'(1)) begin
          rec_resp_d  = dut_out;
          rec_vec_d   = dut_in_q;
          rec_valid_d = 1'b1;
          state_d     = StEmit;
        end else begin
          settle_d = settle_q - SettleCntW'(1);
        end
      end
      StEmit: begin
        // Abort wins over a handshake in the same cycle: the record is discarded.
        if (abort) begin
          rec_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (handshake) begin
          rec_count_d = rec_count_q + CntW'(1);
          sig_enable  = 1'b1;
          rec_valid_d = 1'b0;
          if (rec_vec_q == last_q) begin
            state_d = StDone;
          end else begin
            dut_in_d = dut_in_q + IN_W'(1);
            settle_d = SettleLoad;
            state_d  = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= '0;
      dut_in_q    <= '0;
      rec_vec_q   <= '0;
      rec_resp_q  <= '0;
      rec_valid_q <= 1'b0;
      rec_count_q <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      dut_in_q    <= dut_in_d;
      rec_vec_q   <= rec_vec_d;
      rec_resp_q  <= rec_resp_d;
      rec_valid_q <= rec_valid_d;
      rec_count_q <= rec_count_d;
      settle_q    <= settle_d;
    end
  end

  sweep_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W)
  ) u_misr (
    .clk_i  (CK),
    .rst_ni (reset),
    .clear  (sig_clear),
    .enable (sig_enable),
    .data   (rec_resp_q),
    .sig_o  (signature)
  );

  assign dut_in    = dut_in_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec   = rec_vec_q;
  assign rec_resp  = rec_resp_q;
  assign rec_count = rec_count_q;
  assign busy      = (state_q == StSettle) || (state_q == StEmit);
  assign done      = (state_q == StDone);

endmodule

// File: doc/vector_sweep_engine.md
VECTOR_SWEEP_ENGINE -- requirements
Module: vector_sweep_engine

Interface
REQ-001 The block SHALL have parameter IN_W, default 5, meaning the stimulus vector width (1..16).
REQ-002 The block SHALL have parameter OUT_W, default 1, meaning the DUT response width (1..SIG_W).
REQ-003 The block SHALL have parameter SETTLE, default 1, meaning the number of cycles to hold each vector before sampling (1..255).
REQ-004 The block SHALL have parameter SIG_W, default 16, meaning the signature register width.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset: port CK, input, 1, clock, all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, begin a sweep (sampled in IDLE or DONE only).
REQ-008 The block SHALL have port abort, input, 1, terminate the sweep in progress.
REQ-009 The block SHALL have port first_vec, input, IN_W, first vector (latched on start).
REQ-010 The block SHALL have port last_vec, input, IN_W, last vector (latched on start).
REQ-011 The block SHALL have port dut_in, output, IN_W, stimulus applied to the DUT.
REQ-012 The block SHALL have port dut_out, input, OUT_W, DUT response.
REQ-013 The block SHALL have port rec_valid, output, 1, record available.
REQ-014 The block SHALL have port rec_ready, input, 1, consumer accepts the record.
REQ-015 The block SHALL have port rec_vec, output, IN_W, vector of the current record.
REQ-016 The block SHALL have port rec_resp, output, OUT_W, sampled response of the current record.
REQ-017 The block SHALL have ports busy (output, 1, sweep in progress), done (output, 1, sweep complete, level), rec_count (output, IN_W+1, records accepted) and signature (output, SIG_W, response signature).

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, EMIT and DONE; busy SHALL be 1 exactly in SETTLE and EMIT; done SHALL be 1 exactly in DONE.
REQ-019 On start in IDLE or DONE, the block SHALL latch first/last, set dut_in=first_vec, clear rec_count and signature, load the settle counter with SETTLE, and enter SETTLE.
REQ-020 In SETTLE, the block SHALL hold dut_in; once SETTLE cycles have elapsed, it SHALL sample dut_out into rec_resp, set rec_vec=dut_in, assert rec_valid and enter EMIT.
REQ-021 In EMIT, rec_valid, rec_vec and rec_resp SHALL remain stable until rec_valid&&rec_ready, with no vector skipped or repeated regardless of how long rec_ready stays low.
REQ-022 On handshake, the block SHALL increment rec_count, update signature, and clear rec_valid; if rec_vec==last, it SHALL enter DONE, else it SHALL set dut_in=(dut_in+1) mod 2^IN_W and enter SETTLE.
REQ-023 Signature update SHALL be next=((sig<<1) XOR (sig[SIG_W-1] ? SWEEP_POLY : 0)) XOR zero-extended rec_resp, truncated to SIG_W.
REQ-024 last_vec < first_vec SHALL wrap through 2^IN_W-1 to 0; first==last SHALL produce exactly one record; first=0, last=2^IN_W-1 SHALL produce 2^IN_W records (rec_count needs IN_W+1 bits).
REQ-025 abort in SETTLE or EMIT SHALL enter IDLE at the next edge, drop rec_valid without a handshake, and keep rec_count and signature; abort SHALL take priority over a simultaneous handshake.
REQ-026 start while busy SHALL be ignored; start and abort together in IDLE/DONE SHALL be ignored.

Reset
REQ-027 With reset low at a CK edge, the block SHALL enter IDLE with dut_in, rec_vec, rec_resp, rec_count and signature at 0 and rec_valid, busy and done at 0, overriding any other input, including mid-sweep.

Structure
REQ-028 The state enum, SWEEP_POLY (16'h100B for SIG_W=16) and parameter limits SHALL reside in package sweep_pkg.
REQ-029 The signature register SHALL be a separate sub-module sweep_misr (SIG_W, OUT_W, clear, enable, data).

Verification
REQ-030 IN_W=5, first=0, last=31, rec_ready=1, dut_out=^dut_in: the bench SHALL see 32 records 00000..11111 in order with rec_resp=parity, rec_count=32, then done=1.
REQ-031 rec_ready held low for 3 cycles on the 5th record: the bench SHALL see rec_vec=00100 stable for all 4 cycles and the next record 00101.
REQ-032 first=30, last=1: the bench SHALL see records 30, 31, 0, 1 and rec_count=4.
REQ-033 first=last=7, SETTLE=3: the bench SHALL see exactly one record, with rec_valid rising 3 cycles after dut_in=7.
REQ-034 reset low during record 10: the bench SHALL see IDLE with all outputs 0 at the next edge; abort on record 10 SHALL give rec_count=9 and busy=0.
REQ-035 dut_out constant 1 over 4 records: the bench SHALL see signature match a reference model of REQ-023.
